// File: rtl/sort_pkg.sv
// Shared types and defaults for the frame sorter and its loader.
package sort_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } sort_state_t;

    localparam int FRAME_CNT_W = 16;
    localparam int SORT_N      = 6;
    localparam int SORT_WIDTH  = 8;

endpackage

// File: rtl/frame_buf_bank.sv
// Two N-deep sample banks: one write port with zero-padding above the
// written slot, and a combinational read mux selecting a whole bank.
module frame_buf_bank
    import sort_pkg::*;
#(
    parameter int N     = SORT_N,
    parameter int WIDTH = SORT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic                     i_wr_sel,
    input  logic [$clog2(N)-1:0]     i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pad,
    input  logic                     i_rd_sel,
    output logic [WIDTH-1:0]         o_rd_data [N]
);

    localparam int AW = $clog2(N);

    logic [WIDTH-1:0] r_buf [2][N];

    // Store the sample; on a closing beat also zero every slot above it so
    // short frames present a clean tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    r_buf[b][i] <= '0;
                end
            end
        end else if (i_we) begin
            for (int i = 0; i < N; i++) begin
                if (AW'(i) == i_wr_addr) begin
                    r_buf[i_wr_sel][i] <= i_wr_data;
                end else if (i_pad && (AW'(i) > i_wr_addr)) begin
                    r_buf[i_wr_sel][i] <= '0;
                end
            end
        end
    end

    // Present the selected bank as a parallel frame.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_rd_data[i] = r_buf[i_rd_sel][i];
        end
    end

endmodule

// File: rtl/sort_frame_loader.sv
// Assembles a valid/ready sample stream into N-element frames in a
// ping-pong buffer and hands each complete frame to the sorter.
//
// state   | meaning
// S_IDLE  | no frame under sort; waiting for the sort-side buffer to fill
// S_START | one-cycle start pulse visible, frame counter advances
// S_WAIT  | frame held stable until the sorter reports done
module sort_frame_loader
    import sort_pkg::*;
#(
    parameter int N     = SORT_N,
    parameter int WIDTH = SORT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic                     i_in_last,
    output logic                     o_sort_start,
    input  logic                     i_sort_done,
    output logic [WIDTH-1:0]         o_sort_data [N],
    output logic                     o_frame_err,
    output logic [FRAME_CNT_W-1:0]   o_frame_count
);

    localparam int AW = $clog2(N);

    sort_state_t              r_state;
    sort_state_t              w_state_nxt;
    logic [1:0]               r_full;
    logic [1:0]               w_full_nxt;
    logic                     r_fill_sel;
    logic                     r_sort_sel;
    logic [AW-1:0]            r_wr_cnt;
    logic                     r_sort_start;
    logic                     r_frame_err;
    logic [FRAME_CNT_W-1:0]   r_frame_count;

    logic                     w_hs;
    logic                     w_at_end;
    logic                     w_close;
    logic                     w_err;
    logic                     w_start_nxt;
    logic                     w_release;

    assign o_in_ready    = ~r_full[r_fill_sel];
    assign w_hs          = i_in_valid & o_in_ready;
    assign w_at_end      = (r_wr_cnt == AW'(N - 1));
    assign w_close       = w_hs & (w_at_end | i_in_last);
    // Only a last-flag landing exactly on the final slot is a clean close.
    assign w_err         = w_close & ~(w_at_end & i_in_last);

    assign o_sort_start  = r_sort_start;
    assign o_frame_err   = r_frame_err;
    assign o_frame_count = r_frame_count;

    frame_buf_bank #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_hs),
        .i_wr_sel  (r_fill_sel),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (i_in_data),
        .i_pad     (w_close),
        .i_rd_sel  (r_sort_sel),
        .o_rd_data (o_sort_data)
    );

    // Sort-side next state and strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_sort_sel]) begin
                    w_state_nxt = S_START;
                    w_start_nxt = 1'b1;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_sort_done) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fill-close and release always touch different buffers, so both apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_close) begin
            w_full_nxt[r_fill_sel] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_sort_sel] = 1'b0;
        end
    end

    // Sort-side state, occupancy flags and buffer selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_full     <= '0;
            r_fill_sel <= 1'b0;
            r_sort_sel <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            if (w_close) begin
                r_fill_sel <= ~r_fill_sel;
            end
            if (w_release) begin
                r_sort_sel <= ~r_sort_sel;
            end
        end
    end

    // Write slot pointer within the frame being filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_close) begin
            r_wr_cnt <= '0;
        end else if (w_hs) begin
            r_wr_cnt <= r_wr_cnt + AW'(1);
        end
    end

    // Registered pulses and the handed-off frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sort_start  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_sort_start <= w_start_nxt;
            r_frame_err  <= w_err;
            if (r_state == S_START) begin
                r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader: directed scenarios plus a
// randomized stream, all compared against a frame-level reference model.
module tb_sort_frame_loader;

    localparam int N = 6;
    localparam int W = 8;

    typedef logic [W-1:0] frame_t [N];
    typedef struct {
        logic [W-1:0] d;
        bit           l;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_last = 1'b0;
    logic           sort_start;
    logic           sort_done = 1'b0;
    logic [W-1:0]   sort_data [N];
    logic           frame_err;
    logic [15:0]    frame_count;

    sort_frame_loader #(.N(N), .WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .i_in_last     (in_last),
        .o_sort_start  (sort_start),
        .i_sort_done   (sort_done),
        .o_sort_data   (sort_data),
        .o_frame_err   (frame_err),
        .o_frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input frame_t f);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = f[i];
        return r;
    endfunction

    // Reference model: frames as queues, sorter as "busy with head frame".
    logic [W-1:0] part [$];
    frame_t       pend [$];
    beat_t        src  [$];
    bit           sorting  = 0;
    int           start_at = -1;
    int           err_at   = -1;
    int           cnt      = 0;
    int           t        = 0;

    task automatic push(input logic [W-1:0] d, input bit l);
        beat_t b;
        b.d = d;
        b.l = l;
        src.push_back(b);
    endtask

    // One cycle: check outputs of cycle t, drive inputs, advance the model.
    task automatic cyc(input bit want_v, input bit dn);
        bit     exp_ready;
        bit     v;
        bit     err;
        beat_t  b;
        frame_t f;
        exp_ready = (pend.size() < 2);
        check("in_ready",    64'(in_ready),    64'(exp_ready));
        check("sort_start",  64'(sort_start),  64'(t == start_at));
        check("frame_err",   64'(frame_err),   64'(t == err_at));
        check("frame_count", 64'(frame_count), 64'(cnt[15:0]));
        if (sorting && t >= start_at) check("sort_data", pack(sort_data), pack(pend[0]));
        if (t == start_at) cnt++;

        v         = want_v && (src.size() > 0);
        in_valid  = v;
        in_data   = v ? src[0].d : W'($urandom);
        in_last   = v ? src[0].l : 1'($urandom);
        sort_done = dn;

        if (dn && sorting && t > start_at) begin
            void'(pend.pop_front());
            sorting = 0;
        end
        if (v && exp_ready) begin
            b = src.pop_front();
            part.push_back(b.d);
            if (part.size() == N || b.l) begin
                err = !(part.size() == N && b.l);
                for (int i = 0; i < N; i++) f[i] = (i < part.size()) ? part[i] : '0;
                pend.push_back(f);
                part.delete();
                if (err) err_at = t + 1;
            end
        end
        if (!sorting && pend.size() > 0) begin
            sorting  = 1;
            start_at = t + 2;
        end
        @(negedge clk);
        t++;
    endtask

    task automatic run(input int n, input int pv, input int pd);
        for (int k = 0; k < n; k++)
            cyc($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pd);
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((src.size() > 0 || pend.size() > 0) && k < bound) begin
            cyc(1'b1, 1'($urandom_range(0, 1)));
            k++;
        end
        check("drain_left", 64'(src.size() + pend.size()), 64'(0));
    endtask

    task automatic do_reset(input int ncyc);
        frame_t z;
        for (int i = 0; i < N; i++) z[i] = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sort_done = 1'b0;
        part.delete();
        pend.delete();
        src.delete();
        sorting  = 0;
        start_at = -1;
        err_at   = -1;
        cnt      = 0;
        for (int k = 0; k < ncyc; k++) begin
            #1;
            check("rst_in_ready",    64'(in_ready),    64'(1));
            check("rst_sort_start",  64'(sort_start),  64'(0));
            check("rst_frame_err",   64'(frame_err),   64'(0));
            check("rst_frame_count", 64'(frame_count), 64'(0));
            check("rst_sort_data",   pack(sort_data),  pack(z));
            @(negedge clk);
            t++;
        end
        rst = 1'b0;
    endtask

    logic [W-1:0] seq1 [N];

    initial begin
        seq1[0] = 8'd6; seq1[1] = 8'd2; seq1[2] = 8'd9;
        seq1[3] = 8'd1; seq1[4] = 8'd5; seq1[5] = 8'd3;
        @(negedge clk);
        do_reset(3);

        // First frame, in_last on beat 6.
        for (int i = 0; i < N; i++) push(seq1[i], i == N - 1);
        run(10, 100, 0);
        check("t1_count", 64'(frame_count), 64'(1));

        // Two more frames with sort_done withheld: frame 3 must stall.
        for (int i = 0; i < 2 * N; i++) push(W'($urandom), (i % N) == N - 1);
        run(20, 100, 0);
        check("t2_stalled_beats", 64'(src.size()), 64'(N));
        check("t2_ready_low", 64'(in_ready), 64'(0));
        cyc(1'b0, 1'b1);
        run(6, 0, 0);
        drain(400);

        // Short frame 7,4 then a full frame starting at slot 0.
        push(8'd7, 1'b0);
        push(8'd4, 1'b1);
        for (int i = 0; i < N; i++) push(W'($urandom), i == N - 1);
        run(30, 100, 25);
        drain(400);

        // Twelve beats with no in_last: two length-error closes.
        for (int i = 0; i < 2 * N; i++) push(W'($urandom), 1'b0);
        run(40, 100, 25);
        drain(400);

        // Fill-close coinciding with sort_done.
        for (int i = 0; i < N; i++) push(W'($urandom), i == N - 1);
        run(10, 100, 0);
        for (int i = 0; i < N; i++) push(W'($urandom), i == N - 1);
        for (int i = 0; i < N - 1; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("t5_ready_high", 64'(in_ready), 64'(1));
        run(6, 0, 0);
        drain(400);

        // Reset mid-fill after beat 3.
        for (int i = 0; i < N; i++) push(W'($urandom), i == N - 1);
        run(3, 100, 0);
        do_reset(2);
        for (int i = 0; i < N; i++) push(W'($urandom), i == N - 1);
        run(12, 100, 0);
        check("t6_count", 64'(frame_count), 64'(1));
        drain(400);

        // Reset while the sorter is waiting.
        for (int i = 0; i < N; i++) push(W'($urandom), i == N - 1);
        run(12, 100, 0);
        do_reset(2);
        for (int i = 0; i < N; i++) push(W'($urandom), i == N - 1);
        run(12, 100, 0);
        check("t7_count", 64'(frame_count), 64'(1));
        drain(400);

        // Randomized stream.
        for (int i = 0; i < 900; i++) push(W'($urandom), (i == 899) || ($urandom_range(0, 99) < 15));
        run(2000, 70, 20);
        drain(6000);
        run(5, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
